// File: rtl/transfer_datapath_if.sv
// Memory port of transfer_datapath: the datapath is the master, the memory is the slave.
// Handshake: master raises o_mem_req with o_mem_we/o_mem_addr/o_mem_wdata stable and holds
// all four until the slave returns a one-cycle i_mem_ack (i_mem_rdata valid in that cycle).
interface transfer_datapath_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ack;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata, i_mem_ack
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata, i_mem_ack
  );
endinterface

// File: rtl/transfer_datapath.sv
// CPU register file + transfer executor with a stalling req/ack memory port.
// Optional bus-timeout abort is enabled with `define DATAPATH_BUS_TIMEOUT_EN.
module transfer_datapath #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
`ifdef DATAPATH_BUS_TIMEOUT_EN
  , parameter int              TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [3:0]        i_transfer_cmd,
  input  logic              i_inc_pc,
  input  logic [1:0]        i_inc_dec_sp,
  input  logic              i_mem_write_enable,
  input  logic              i_ap_sel,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_in_data,
  output logic [DATA_W-1:0] o_opcode,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_ap,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_stall,
  output logic              o_bus_err,
  transfer_datapath_if.master mem,
  output logic [1:0]        o_dbg_state,
  output logic [ADDR_W-1:0] o_dbg_pc,
  output logic [ADDR_W-1:0] o_dbg_sp,
  output logic [ADDR_W-1:0] o_dbg_ma,
  output logic [DATA_W-1:0] o_dbg_md
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc, sp, ma;
  logic [DATA_W-1:0] md, ir, a, ap, out_data;
  logic              pend_inc_pc;
  logic [1:0]        pend_sp;
  logic              mem_wr, mem_cmd, done, timeout;

  assign mem_wr  = (i_transfer_cmd == 4'h9) || i_mem_write_enable;
  assign mem_cmd = mem_wr || (i_transfer_cmd == 4'h2);
  assign done    = (state != IDLE) && (mem.i_mem_ack || timeout);
  assign o_stall = (state == IDLE) ? mem_cmd : !done;

  function automatic logic [ADDR_W-1:0] sp_next(input logic [ADDR_W-1:0] cur, input logic [1:0] op);
    case (op)
      2'b01:   sp_next = cur + 1'b1;
      2'b10:   sp_next = cur - 1'b1;
      default: sp_next = cur;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state           <= IDLE;
      pc              <= PC_RESET;
      sp              <= SP_RESET;
      ma              <= '0;
      md              <= '0;
      ir              <= '0;
      a               <= '0;
      ap              <= '0;
      out_data        <= '0;
      pend_inc_pc     <= 1'b0;
      pend_sp         <= 2'b00;
      mem.o_mem_req   <= 1'b0;
      mem.o_mem_we    <= 1'b0;
      mem.o_mem_addr  <= '0;
      mem.o_mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_cmd) begin
            // Issue only: PC/SP requests are parked until the access completes.
            state           <= mem_wr ? WR_WAIT : RD_WAIT;
            mem.o_mem_req   <= 1'b1;
            mem.o_mem_we    <= mem_wr;
            mem.o_mem_addr  <= ma;
            mem.o_mem_wdata <= md;
            pend_inc_pc     <= i_inc_pc;
            pend_sp         <= i_inc_dec_sp;
          end else begin
            case (i_transfer_cmd)
              4'h1: ma <= pc;
              4'h3: ir <= md;
              4'h4: ma <= md;
              4'h5: if (i_ap_sel) ap <= md; else a <= md;
              4'h6: ma <= ap;
              4'h7: ma <= sp;
              4'h8: md <= i_ap_sel ? ap : a;
              4'hA: if (i_ap_sel) ap <= i_alu_result; else a <= i_alu_result;
              4'hC: a <= i_in_data;
              4'hD: out_data <= a;
              4'hF: md <= pc;
              default: ;
            endcase
            // PC loads override the increment request.
            if (i_transfer_cmd == 4'hB)      pc <= md;
            else if (i_transfer_cmd == 4'hE) pc <= ap;
            else if (i_inc_pc)               pc <= pc + 1'b1;
            sp <= sp_next(sp, i_inc_dec_sp);
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (done) begin
            // A timed-out read returns all ones; a timed-out write is simply dropped.
            if (state == RD_WAIT) md <= mem.i_mem_ack ? mem.i_mem_rdata : '1;
            if (pend_inc_pc) pc <= pc + 1'b1;
            sp            <= sp_next(sp, pend_sp);
            state         <= IDLE;
            mem.o_mem_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATAPATH_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt = number of wait cycles already spent; abort in wait cycle TIMEOUT_CYCLES.
  assign timeout = (state != IDLE) && !mem.i_mem_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_bus_err = timeout;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)            wait_cnt <= '0;
    else if (state == IDLE) wait_cnt <= '0;
    else                    wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout   = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  assign o_opcode    = ir;
  assign o_a         = a;
  assign o_ap        = ap;
  assign o_out_data  = out_data;
  assign o_dbg_state = state;
  assign o_dbg_pc    = pc;
  assign o_dbg_sp    = sp;
  assign o_dbg_ma    = ma;
  assign o_dbg_md    = md;
endmodule

// File: tb/tb_transfer_datapath.sv
// Randomized + directed bench for transfer_datapath against a per-command reference model.
module tb_transfer_datapath;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [3:0]   transfer_cmd;
  logic         inc_pc;
  logic [1:0]   inc_dec_sp;
  logic         mem_write_enable;
  logic         ap_sel;
  logic [W-1:0] alu_result, in_data;
  logic [W-1:0] opcode, a_out, ap_out, out_data;
  logic         stall, bus_err;
  logic [1:0]   dbg_state;
  logic [W-1:0] dbg_pc, dbg_sp, dbg_ma, dbg_md;

  transfer_datapath_if #(.DATA_W(W), .ADDR_W(W)) mem_bus ();

  transfer_datapath dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_transfer_cmd     (transfer_cmd),
    .i_inc_pc           (inc_pc),
    .i_inc_dec_sp       (inc_dec_sp),
    .i_mem_write_enable (mem_write_enable),
    .i_ap_sel           (ap_sel),
    .i_alu_result       (alu_result),
    .i_in_data          (in_data),
    .o_opcode           (opcode),
    .o_a                (a_out),
    .o_ap               (ap_out),
    .o_out_data         (out_data),
    .o_stall            (stall),
    .o_bus_err          (bus_err),
    .mem                (mem_bus),
    .o_dbg_state        (dbg_state),
    .o_dbg_pc           (dbg_pc),
    .o_dbg_sp           (dbg_sp),
    .o_dbg_ma           (dbg_ma),
    .o_dbg_md           (dbg_md)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] m_pc, m_sp, m_ma, m_md, m_ir, m_a, m_ap, m_out;
  logic [W-1:0] mem_arr [256];
  logic [16:0]  exp_q[$];   // {we, addr, wdata} of the access the datapath must issue
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_sp = 8'hFF;
    m_ma = 0; m_md = 0; m_ir = 0; m_a = 0; m_ap = 0; m_out = 0;
  endtask

  function automatic logic [W-1:0] sp_after(input logic [W-1:0] s, input logic [1:0] op);
    int v;
    v = int'(s);
    if (op == 2'b01) v = v + 1;
    if (op == 2'b10) v = v - 1;
    return W'((v + 256) % 256);
  endfunction

  // One non-memory command: every source is read before any destination is written.
  task automatic model_transfer(input logic [3:0] cmd, input logic inc, input logic [1:0] spop,
                                input logic sel, input logic [W-1:0] alu, input logic [W-1:0] inv);
    logic [W-1:0] pc0, sp0, md0, a0, ap0;
    pc0 = m_pc; sp0 = m_sp; md0 = m_md; a0 = m_a; ap0 = m_ap;
    case (cmd)
      4'h1: m_ma = pc0;
      4'h3: m_ir = md0;
      4'h4: m_ma = md0;
      4'h5: if (sel) m_ap = md0; else m_a = md0;
      4'h6: m_ma = ap0;
      4'h7: m_ma = sp0;
      4'h8: m_md = sel ? ap0 : a0;
      4'hA: if (sel) m_ap = alu; else m_a = alu;
      4'hC: m_a = inv;
      4'hD: m_out = a0;
      4'hF: m_md = pc0;
      default: ;
    endcase
    if (cmd == 4'hB)      m_pc = md0;
    else if (cmd == 4'hE) m_pc = ap0;
    else if (inc)         m_pc = W'((int'(pc0) + 1) % 256);
    m_sp = sp_after(sp0, spop);
  endtask

  task automatic check_regs(input string where);
    check({where, "_pc"},  dbg_pc,   m_pc);
    check({where, "_sp"},  dbg_sp,   m_sp);
    check({where, "_ma"},  dbg_ma,   m_ma);
    check({where, "_md"},  dbg_md,   m_md);
    check({where, "_ir"},  opcode,   m_ir);
    check({where, "_a"},   a_out,    m_a);
    check({where, "_ap"},  ap_out,   m_ap);
    check({where, "_out"}, out_data, m_out);
    check({where, "_req"}, mem_bus.o_mem_req, 0);
    check({where, "_st"},  dbg_state, 0);
  endtask

  // ---------------- driver ----------------
  task automatic drive_nop();
    transfer_cmd = 0; inc_pc = 0; inc_dec_sp = 0; mem_write_enable = 0;
    ap_sel = 0; alu_result = 0; in_data = 0;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that completes the command.
  task automatic do_step(input logic [3:0] cmd, input logic inc, input logic [1:0] spop,
                         input logic we, input logic sel, input logic [W-1:0] alu,
                         input logic [W-1:0] inv, input int lat);
    logic         is_mem, is_wr;
    logic [16:0]  e;
    logic [W-1:0] rd;
    int           n_wait;
    transfer_cmd = cmd; inc_pc = inc; inc_dec_sp = spop; mem_write_enable = we;
    ap_sel = sel; alu_result = alu; in_data = inv;
    is_mem = we || (cmd == 4'h2) || (cmd == 4'h9);
    @(negedge clk);
    check("stall_issue", stall, is_mem);
    if (!is_mem) begin
      model_transfer(cmd, inc, spop, sel, alu, inv);
      @(posedge clk); #1;
    end else begin
      is_wr = we || (cmd == 4'h9);
      exp_q.push_back({is_wr, m_ma, m_md});
      @(posedge clk); #1;
      // Scramble inputs while waiting: the datapath must use the issued command.
      transfer_cmd = 4'($urandom); inc_pc = 1'($urandom); inc_dec_sp = 2'($urandom);
      mem_write_enable = 1'($urandom); ap_sel = 1'($urandom);
      mem_bus.i_mem_rdata = W'($urandom);
      e = exp_q.pop_front();
      n_wait = (lat < 0) ? $urandom_range(0, 3) : lat;
      for (int k = 0; k < n_wait; k++) begin
        @(negedge clk);
        check("wait_stall", stall, 1);
        check("wait_req",   mem_bus.o_mem_req, 1);
        check("wait_we",    mem_bus.o_mem_we, e[16]);
        check("wait_addr",  mem_bus.o_mem_addr, e[15:8]);
        check("wait_wdata", mem_bus.o_mem_wdata, e[7:0]);
        @(posedge clk); #1;
      end
      rd = mem_arr[e[15:8]];
      mem_bus.i_mem_ack = 1'b1;
      mem_bus.i_mem_rdata = rd;
      @(negedge clk);
      check("ack_stall", stall, 0);
      check("ack_req",   mem_bus.o_mem_req, 1);
      check("ack_addr",  mem_bus.o_mem_addr, e[15:8]);
      check("ack_berr",  bus_err, 0);
      @(posedge clk); #1;
      mem_bus.i_mem_ack = 1'b0;
      if (e[16]) mem_arr[e[15:8]] = e[7:0];
      else       m_md = rd;
      if (inc) m_pc = W'((int'(m_pc) + 1) % 256);
      m_sp = sp_after(m_sp, spop);
    end
    drive_nop();
    check_regs("step");
  endtask

  task automatic set_md(input logic [W-1:0] v);
    do_step(4'hC, 0, 0, 0, 0, 0, v, 0);
    do_step(4'h8, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = W'($urandom);
    drive_nop();
    mem_bus.i_mem_ack = 0; mem_bus.i_mem_rdata = 0;
    rstn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1;
    model_reset();
    @(posedge clk); #1;
    check_regs("reset");
    check("reset_berr", bus_err, 0);
    check("reset_stall", stall, 0);

    // Read with PC increment, 3 wait cycles
    set_md(8'h10);
    do_step(4'h4, 0, 0, 0, 0, 0, 0, 0);
    mem_arr[8'h10] = 8'hA5;
    do_step(4'h2, 1, 0, 0, 0, 0, 0, 3);
    check("rd_md", dbg_md, 8'hA5);

    // Write MD=0x3C to 0x80, ack in first wait cycle, then read back
    set_md(8'h80);
    do_step(4'h4, 0, 0, 0, 0, 0, 0, 0);
    set_md(8'h3C);
    do_step(4'h0, 0, 0, 1, 0, 0, 0, 0);
    check("wr_mem", mem_arr[8'h80], 8'h3C);
    set_md(8'h00);
    do_step(4'h2, 0, 0, 0, 0, 0, 0, 1);
    check("wr_readback", dbg_md, 8'h3C);

    // Wrap-around of SP and PC
    do_step(4'h0, 0, 2'b01, 0, 0, 0, 0, 0);
    check("sp_inc_wrap", dbg_sp, 8'h00);
    do_step(4'h0, 0, 2'b10, 0, 0, 0, 0, 0);
    check("sp_dec_wrap", dbg_sp, 8'hFF);
    do_step(4'h0, 0, 2'b11, 0, 0, 0, 0, 0);
    check("sp_hold", dbg_sp, 8'hFF);
    set_md(8'hFF);
    do_step(4'hB, 0, 0, 0, 0, 0, 0, 0);
    do_step(4'h0, 1, 0, 0, 0, 0, 0, 0);
    check("pc_wrap", dbg_pc, 8'h00);

    // Transfer corner cases
    do_step(4'hC, 0, 0, 0, 0, 0, 8'h11, 0);
    do_step(4'hA, 0, 0, 0, 1, 8'h42, 0, 0);
    check("cmdA_ap", ap_out, 8'h42);
    check("cmdA_a", a_out, 8'h11);
    set_md(8'h07);
    do_step(4'hB, 0, 0, 0, 0, 0, 0, 0);
    do_step(4'hF, 1, 0, 0, 0, 0, 0, 0);
    check("cmdF_md", dbg_md, 8'h07);
    check("cmdF_pc", dbg_pc, 8'h08);
    set_md(8'h20);
    do_step(4'hB, 1, 0, 0, 0, 0, 0, 0);
    check("cmdB_pc", dbg_pc, 8'h20);

    // Randomized command stream
    for (int n = 0; n < 250; n++) begin
      do_step(4'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
              ($urandom_range(0, 9) == 0), 1'($urandom), W'($urandom), W'($urandom), -1);
    end

    // Asynchronous reset in the middle of a read
    transfer_cmd = 4'h2;
    @(posedge clk); #1;
    check("rst_pre_req", mem_bus.o_mem_req, 1);
    #2 rstn = 0;
    #1;
    check("rst_req_drop", mem_bus.o_mem_req, 0);
    model_reset();
    drive_nop();
    check_regs("rst_mid");
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    mem_bus.i_mem_ack = 1; mem_bus.i_mem_rdata = 8'h5A;
    @(posedge clk); #1;
    mem_bus.i_mem_ack = 0;
    check_regs("late_ack");

`ifdef DATAPATH_BUS_TIMEOUT_EN
    // Read that never gets an ack aborts in wait cycle 16
    transfer_cmd = 4'h2; inc_pc = 1;
    @(posedge clk); #1;
    drive_nop();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("to_berr",  bus_err, (k == 16));
      check("to_stall", stall, (k != 16));
      @(posedge clk); #1;
    end
    m_md = 8'hFF;
    m_pc = W'((int'(m_pc) + 1) % 256);
    check_regs("timeout");
    mem_bus.i_mem_ack = 1; mem_bus.i_mem_rdata = 8'h33;
    @(posedge clk); #1;
    mem_bus.i_mem_ack = 0;
    check_regs("to_late_ack");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
